// File: rtl/ifetch_unit.sv
// Instruction fetch front end: issues word reads from a redirectable PC,
// buffers {pc, instr} pairs in an in-order queue and presents the head to decode.
module ifetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        mem_req_valid,
  output logic [31:0] mem_req_addr,
  input  logic        mem_req_ready,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_data,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready
);

  // Handshakes: a transfer happens on any rising edge where valid and ready
  // are both high; valid never depends combinationally on ready.
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_DROP} state_e;

  state_e          state_q, state_d;
  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic [31:0]     req_pc_q, req_pc_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            req_valid_q, req_valid_d;
  logic [31:0]     pc_mem    [DEPTH];
  logic [31:0]     instr_mem [DEPTH];

  logic req_hs;
  logic push;
  logic pop;
  logic busy_next;
  logic unused_pc_lsbs;

  assign unused_pc_lsbs = ^redirect_pc[1:0];

  always_comb begin
    req_hs      = req_valid_q && mem_req_ready;
    push        = (state_q == S_WAIT) && mem_rsp_valid && !redirect;
    pop         = (count_q != '0) && instr_ready && !redirect;
    busy_next   = ((state_q != S_REQ) && !mem_rsp_valid) || req_hs;
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    req_pc_d    = req_pc_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    case (state_q)
      S_REQ: begin
        if (req_hs) begin
          state_d    = S_WAIT;
          req_pc_d   = fetch_pc_q;
          fetch_pc_d = fetch_pc_q + 32'd4;
        end
      end
      S_WAIT:  if (mem_rsp_valid) state_d = S_REQ;
      S_DROP:  if (mem_rsp_valid) state_d = S_REQ;
      default: state_d = S_REQ;
    endcase
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    count_d = count_q + CW'(push) - CW'(pop);
    // A redirect flushes everything; an in-flight read must still be drained.
    if (redirect) begin
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      state_d    = busy_next ? S_DROP : S_REQ;
    end
    req_valid_d = (state_d == S_REQ) && (count_d < CW'(DEPTH));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_REQ;
      fetch_pc_q  <= RESET_PC;
      req_pc_q    <= RESET_PC;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      req_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      req_pc_q    <= req_pc_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      req_valid_q <= req_valid_d;
    end
  end

  // Queue storage needs no reset: entries are only visible while counted.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_q]    <= req_pc_q;
      instr_mem[wr_ptr_q] <= mem_rsp_data;
    end
  end

  assign mem_req_valid = req_valid_q;
  assign mem_req_addr  = fetch_pc_q;
  assign instr_valid   = (count_q != '0);
  assign instr         = instr_valid ? instr_mem[rd_ptr_q] : 32'h0;
  assign instr_pc      = instr_valid ? pc_mem[rd_ptr_q] : 32'h0;

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: directed scenarios plus random traffic
// against a transaction-level model of the fetch queue and memory.
module tb_ifetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic        mem_req_ready = 1'b0;
  logic        mem_rsp_valid = 1'b0;
  logic [31:0] mem_rsp_data = 32'h0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready = 1'b0;

  always #5 clk = ~clk;

  ifetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .redirect(redirect), .redirect_pc(redirect_pc),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr),
    .mem_req_ready(mem_req_ready), .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_data(mem_rsp_data), .instr_valid(instr_valid), .instr(instr),
    .instr_pc(instr_pc), .instr_ready(instr_ready)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model: what decode should see, plus the single-read credit.
  typedef struct packed {logic [31:0] pc; logic [31:0] ins;} ent_t;
  ent_t        m_q[$];
  logic [31:0] m_fpc, m_out_pc;
  bit          m_out, m_stale, m_req_v;

  // Memory environment.
  bit          mem_busy;
  logic [31:0] mem_addr;
  int          mem_cnt;
  logic [31:0] salt = 32'd1;
  bit          rand_lat = 1'b0;
  logic [31:0] slow_addr = 32'hFFFF_FFFF;
  int          slow_lat = 1;

  logic [31:0] pop_pc[$], pop_ins[$], req_pc[$];
  int          pop_cyc[$], req_cyc[$], rsp_cyc[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_fpc = RESET_PC; m_out_pc = RESET_PC;
    m_out = 1'b0; m_stale = 1'b0; m_req_v = 1'b0;
  endtask

  // Applies the effect of the coming rising edge, given the inputs now driven.
  task automatic model_update();
    bit hs, pop;
    ent_t e;
    hs  = m_req_v && mem_req_ready;
    pop = (m_q.size() > 0) && instr_ready;
    chk("rsp_without_request", 32'(mem_rsp_valid && !m_out), 32'h0);
    if (redirect) begin
      m_q.delete();
      m_fpc = {redirect_pc[31:2], 2'b00};
      if ((m_out && !mem_rsp_valid) || hs) begin
        m_out = 1'b1; m_stale = 1'b1;
      end else begin
        m_out = 1'b0; m_stale = 1'b0;
      end
    end else begin
      if (pop) void'(m_q.pop_front());
      if (m_out && mem_rsp_valid) begin
        if (!m_stale) begin
          e.pc = m_out_pc; e.ins = mem_rsp_data;
          m_q.push_back(e);
        end
        m_out = 1'b0; m_stale = 1'b0;
      end
      if (hs) begin
        m_out_pc = m_fpc; m_fpc = m_fpc + 32'd4;
        m_out = 1'b1; m_stale = 1'b0;
      end
    end
    m_req_v = !m_out && (m_q.size() < DEPTH);
  endtask

  task automatic compare();
    chk("mem_req_valid", 32'(mem_req_valid), 32'(m_req_v));
    chk("mem_req_addr", mem_req_addr, m_fpc);
    chk("instr_valid", 32'(instr_valid), 32'(m_q.size() > 0));
    if (m_q.size() > 0) begin
      chk("instr", instr, m_q[0].ins);
      chk("instr_pc", instr_pc, m_q[0].pc);
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    if (rst_n) compare();
    redirect = 1'b0;
  endtask

  task automatic commit();
    if (mem_busy) chk("single_outstanding", 32'(mem_req_valid), 32'h0);
    mem_rsp_valid = 1'b0;
    if (mem_busy) begin
      if (mem_cnt == 1) begin
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = mem_addr + salt;
        mem_busy      = 1'b0;
        rsp_cyc.push_back(cyc);
      end else begin
        mem_cnt--;
      end
    end
    if (mem_req_valid && mem_req_ready) begin
      mem_busy = 1'b1;
      mem_addr = mem_req_addr;
      mem_cnt  = (mem_req_addr == slow_addr) ? slow_lat :
                 (rand_lat ? int'($urandom_range(1, 4)) : 1);
      req_pc.push_back(mem_req_addr);
      req_cyc.push_back(cyc);
    end
    if (instr_valid && instr_ready && !redirect) begin
      pop_pc.push_back(instr_pc);
      pop_ins.push_back(instr);
      pop_cyc.push_back(cyc);
    end
    model_update();
  endtask

  task automatic reset_checks();
    chk("rst_mem_req_valid", 32'(mem_req_valid), 32'h0);
    chk("rst_mem_req_addr", mem_req_addr, RESET_PC);
    chk("rst_instr_valid", 32'(instr_valid), 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_instr_pc", instr_pc, 32'h0);
  endtask

  task automatic assert_reset();
    rst_n = 1'b0;
    redirect = 1'b0;
    mem_busy = 1'b0;
    mem_rsp_valid = 1'b0;
    model_reset();
    pop_pc.delete(); pop_ins.delete(); pop_cyc.delete();
    req_pc.delete(); req_cyc.delete(); rsp_cyc.delete();
  endtask

  task automatic do_reset();
    assert_reset();
    repeat (2) @(negedge clk);
    reset_checks();
    rst_n = 1'b1;
    commit();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bit done, found;
    int red_cyc, p;

    // Streaming at the 2-cycle cadence with a 1-cycle memory.
    instr_ready = 1'b1; mem_req_ready = 1'b1;
    do_reset();
    step();
    chk("t1_first_req_valid", 32'(mem_req_valid), 32'h1);
    chk("t1_first_req_addr", mem_req_addr, RESET_PC);
    commit();
    for (int i = 0; i < 20 && pop_pc.size() < 4; i++) begin step(); commit(); end
    chk("t1_pops", 32'(pop_pc.size()), 32'd4);
    if (pop_pc.size() >= 4) begin
      for (int i = 0; i < 4; i++) begin
        chk("t1_pc", pop_pc[i], 32'(4 * i));
        chk("t1_instr", pop_ins[i], 32'(4 * i + 1));
        if (i > 0) chk("t1_cadence", 32'(pop_cyc[i] - pop_cyc[i-1]), 32'd2);
      end
    end

    // Back-pressure: queue fills, requests stop, pops restart them.
    instr_ready = 1'b0;
    do_reset();
    repeat (12) begin step(); commit(); end
    step();
    chk("t2_req_stalled", 32'(mem_req_valid), 32'h0);
    chk("t2_head_valid", 32'(instr_valid), 32'h1);
    chk("t2_head_pc", instr_pc, 32'h0);
    chk("t2_reqs", 32'(req_pc.size()), 32'd2);
    instr_ready = 1'b1;
    p = cyc;
    commit();
    for (int i = 0; i < 10 && req_pc.size() < 3; i++) begin step(); commit(); end
    chk("t2_reqs_after", 32'(req_pc.size()), 32'd3);
    if (req_pc.size() >= 3 && pop_pc.size() >= 2) begin
      chk("t2_pop0", pop_pc[0], 32'h0);
      chk("t2_pop1", pop_pc[1], 32'h4);
      chk("t2_req8_addr", req_pc[2], 32'h8);
      chk("t2_req8_cycle", 32'(req_cyc[2]), 32'(p + 1));
    end

    // Redirect while waiting; the stale read returns three cycles later.
    slow_addr = 32'h4; slow_lat = 3;
    do_reset();
    done = 1'b0; red_cyc = 0;
    for (int i = 0; i < 40 && pop_pc.size() < 3; i++) begin
      step();
      if (done && cyc == red_cyc + 1) chk("t3_flushed", 32'(instr_valid), 32'h0);
      if (!done && mem_busy && mem_addr == 32'h4) begin
        redirect = 1'b1; redirect_pc = 32'h0000_0100; done = 1'b1; red_cyc = cyc;
      end
      commit();
    end
    chk("t3_pops", 32'(pop_pc.size()), 32'd3);
    if (pop_pc.size() >= 3 && req_pc.size() >= 3 && rsp_cyc.size() >= 2) begin
      chk("t3_pop0", pop_pc[0], 32'h0);
      chk("t3_pop1", pop_pc[1], 32'h100);
      chk("t3_instr1", pop_ins[1], 32'h101);
      chk("t3_pop2", pop_pc[2], 32'h104);
      chk("t3_req_target", req_pc[2], 32'h100);
      chk("t3_req_after_stale", 32'(req_cyc[2]), 32'(rsp_cyc[1] + 1));
    end
    slow_addr = 32'hFFFF_FFFF;

    // Redirect coinciding with a request handshake and a head pop.
    do_reset();
    done = 1'b0; red_cyc = 0;
    for (int i = 0; i < 30 && pop_pc.size() < 2; i++) begin
      step();
      if (done && cyc == red_cyc + 1) chk("t4_flushed", 32'(instr_valid), 32'h0);
      if (!done && instr_valid && mem_req_valid) begin
        redirect = 1'b1; redirect_pc = 32'h0000_0040; done = 1'b1; red_cyc = cyc;
      end
      commit();
    end
    chk("t4_pops", 32'(pop_pc.size()), 32'd2);
    if (pop_pc.size() >= 2) begin
      chk("t4_pop0", pop_pc[0], 32'h40);
      chk("t4_instr0", pop_ins[0], 32'h41);
      chk("t4_pop1", pop_pc[1], 32'h44);
    end

    // Target alignment and address wrap.
    mem_req_ready = 1'b0;
    do_reset();
    step();
    redirect = 1'b1; redirect_pc = 32'h0000_0203;
    commit();
    step();
    chk("t5_aligned_valid", 32'(mem_req_valid), 32'h1);
    chk("t5_aligned_addr", mem_req_addr, 32'h0000_0200);
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    commit();
    step();
    chk("t5_wrap_target", mem_req_addr, 32'hFFFF_FFFC);
    mem_req_ready = 1'b1;
    commit();
    for (int i = 0; i < 20 && pop_pc.size() < 2; i++) begin step(); commit(); end
    chk("t5_pops", 32'(pop_pc.size()), 32'd2);
    if (pop_pc.size() >= 2) begin
      chk("t5_pop0", pop_pc[0], 32'hFFFF_FFFC);
      chk("t5_instr0", pop_ins[0], 32'hFFFF_FFFD);
      chk("t5_pop1", pop_pc[1], 32'h0);
      chk("t5_instr1", pop_ins[1], 32'h1);
    end

    // Asynchronous reset with a read outstanding and no credit left.
    instr_ready = 1'b0; slow_addr = 32'h4; slow_lat = 6;
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (mem_busy && mem_addr == 32'h4) found = 1'b1;
      else commit();
    end
    chk("t6_reached", 32'(found), 32'h1);
    chk("t6_head_valid", 32'(instr_valid), 32'h1);
    chk("t6_no_credit", 32'(mem_req_valid), 32'h0);
    commit();
    #2;
    assert_reset();
    #1;
    reset_checks();
    slow_addr = 32'hFFFF_FFFF;
    @(negedge clk);
    rst_n = 1'b1;
    commit();
    step();
    chk("t6_restart_valid", 32'(mem_req_valid), 32'h1);
    chk("t6_restart_addr", mem_req_addr, RESET_PC);
    commit();

    // Random traffic against the model.
    rand_lat = 1'b1; salt = $urandom;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      step();
      instr_ready   = ($urandom_range(0, 9) < 7);
      mem_req_ready = ($urandom_range(0, 9) < 6);
      if ($urandom_range(0, 19) == 0) begin
        redirect = 1'b1;
        redirect_pc = ($urandom_range(0, 3) == 0) ?
                      (32'hFFFF_FFF0 + 32'($urandom_range(0, 15))) : $urandom;
      end
      commit();
    end
    chk("rand_progress", 32'(pop_pc.size() > 100), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
